rng_icdf_sampler: RTL and testbench
===================================

Name: rng_icdf_sampler

Overview:
Parametrised successor to the single-shot uniform-to-float/lookup RNG path. Consumes BX-bit uniform words over a valid/ready handshake and extends the octave (leading-zero) count across as many words as needed, up to a per-part clamp. It then evaluates a piecewise-linear inverse CDF (c0 + c1·frac) from a sectioned coefficient ROM. Results are buffered in an output FIFO with backpressure, between the LVDS uniform RNG and downstream consumers.

Parameters:
BX, 16, uniform word width; layout [BX-1] symm, [BX-2] part, [BX-3:MANT_BW] exponent field, [MANT_BW-1:0] mantissa
MANT_BW, 8, mantissa width; EXP_BW = BX-2-MANT_BW (>=1)
K, 3, subsection bits (mantissa MSBs); MANT_BW-K >= 1
BY, 16, output sample width
G_OCT, 10, max octave for part=0
D_OCT, 6, max octave for part=1
OUT_DEPTH, 4, output FIFO depth, power of 2, >= 2
C0_FILE, "c0.mem", hex init file for c0 ROM
C1_FILE, "c1.mem", hex init file for c1 ROM

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  uniform word valid
in_ready  out  1  sampler accepts word this cycle
in_data  in  BX  uniform word
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer pops head when out_valid
out_data  out  BY  FIFO head sample
busy  out  1  FSM not in S_FIRST

Behaviour:
- Reset: asynchronous, active-high, on rst. All regs clear; FSM = S_FIRST; FIFO empty. Outputs: out_valid=0, out_data=0, busy=0, in_ready=1 after release.
- Transfer: in_valid & in_ready at a rising edge. in_ready = 1 only in S_FIRST and S_EXT.
- S_FIRST: on transfer, latch symm, part, mantissa. Set acc = clz(exponent field), limited to EXP_BW. Set max = part ? D_OCT : G_OCT.
  - Field nonzero, or acc >= max: oct = min(acc, max) -> S_LOOK.
  - Otherwise -> S_EXT.
- S_EXT: on transfer, use only the new word's exponent field. acc += clz(field).
  - Field nonzero, or acc >= max: oct = min(acc, max) -> S_LOOK.
  - Otherwise stay in S_EXT.
  - acc width = clog2(max(G_OCT,D_OCT)+EXP_BW)+1; no wrap.
- Clamp: once acc >= max, no further word is consumed for that sample.
- S_LOOK: synchronous ROM read, one cycle -> S_MAC.
  - sub = mantissa[MANT_BW-1 -: K].
  - section = part ? (G_OCT+1+oct) : oct.
  - addr = section·2^K + sub.
  - ROM depth (G_OCT+D_OCT+2)·2^K.
- S_MAC: y = c0 + ((c1 · frac) >> (MANT_BW-K)), frac = mantissa[MANT_BW-K-1:0]. Full-width product; sum truncated to BY. Register y -> S_PUSH.
- S_PUSH: if FIFO not full, write y -> S_FIRST. Else hold y and stay.
- Latency: final word accepted at edge T -> FIFO write at edge T+3 -> out_valid high after T+3 (empty FIFO).
- Throughput: at most 1 sample per 4 cycles.
- FIFO: first-word fall-through. Simultaneous push and pop when full is not possible, since push waits for not-full. Push and pop together when non-empty: occupancy unchanged.
- Reset mid-sample: partial acc and any held y are discarded; FIFO contents are lost.

Optional Feature:
RNG_SYMM_EN
- Defined: written sample = symm ? (~y + 1) : y, two's complement in BY bits, applied in S_MAC.
- Undefined: symm bit ignored; sample = y. Port list unchanged.

Decomposition:
- Shared rng.vh: word-layout macros (field offsets for symm, part, exponent, mantissa); section-address macro; ROM depth macro; default G_OCT, D_OCT, K, BY.
- Existing CLOG2/MAX in utils.vh.
- One natural sub-module: rng_out_fifo (parametrised BY × OUT_DEPTH, fall-through, async active-high rst on rst).

Test Plan:
All cases use defaults, c0[i]=i, c1=0 unless noted.
1. Single word, no extension: in 16'h2480 -> oct 0, sub 4 -> out_data 16'h0004 three cycles after accept.
2. Single word, nonzero clz: in 16'h0180 -> oct 5, addr 44 -> out 16'h002C.
3. Extension: in 16'h00A0, then 16'h0400 -> 2 words consumed, oct 6+3=9, sub 5 -> out 16'h004D.
4. Clamp, part=1: in 16'h4000 then 16'h0000 -> only the first word consumed (acc 6 = D_OCT), addr (17)·8+0 -> out 16'h0088. The second word 16'h0000 starts a new sample.
5. Backpressure: out_ready=0, feed 6 words with nonzero exponent -> 4 samples buffered, FSM holds in S_PUSH, in_ready=0. Release out_ready -> all 5 samples drain in order, no loss.
6. MAC and reset: c0[4]=16'h0100, c1[4]=16'h0040, in 16'h249F (frac 31) -> out 16'h013E.
   - With RNG_SYMM_EN and in 16'hA49F -> out 16'hFEC2.
   - Assert rst while in S_EXT -> out_valid=0, busy=0 immediately; the next word starts a fresh sample.

Source files
------------

// File: rtl/rng_icdf_sampler_pkg.sv
// rng_icdf_sampler_pkg: FSM state encoding and elaboration-time helpers shared by the sampler.
package rng_icdf_sampler_pkg;

    typedef enum logic [2:0] {
        S_FIRST = 3'd0,
        S_EXT   = 3'd1,
        S_LOOK  = 3'd2,
        S_MAC   = 3'd3,
        S_PUSH  = 3'd4
    } state_t;

    function automatic int max2(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/rng_out_fifo.sv
// rng_out_fifo: first-word fall-through sample FIFO, W bits x DEPTH entries (DEPTH a power of 2).
module rng_out_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem_r [DEPTH];
    logic [PW:0]  wr_ptr_r;
    logic [PW:0]  rd_ptr_r;
    logic         empty_s;
    logic         pop_s;

    // The extra pointer bit separates full from empty when the indices match.
    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    assign pop_s     = out_ready && !empty_s;
    assign out_valid = !empty_s;
    assign out_data  = empty_s ? {W{1'b0}} : mem_r[rd_ptr_r[PW-1:0]];

    // Storage and pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                mem_r[wr_ptr_r[PW-1:0]] <= push_data;
                wr_ptr_r                <= wr_ptr_r + {{PW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{PW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/rng_icdf_sampler.sv
// rng_icdf_sampler: multi-word octave count, piecewise-linear inverse CDF, buffered output.
// Optional macro RNG_SYMM_EN: negate the sample when the first word's symm bit is set.
module rng_icdf_sampler
    import rng_icdf_sampler_pkg::*;
#(
    parameter int    BX        = 16,
    parameter int    MANT_BW   = 8,
    parameter int    K         = 3,
    parameter int    BY        = 16,
    parameter int    G_OCT     = 10,
    parameter int    D_OCT     = 6,
    parameter int    OUT_DEPTH = 4,
    parameter string C0_FILE   = "c0.mem",
    parameter string C1_FILE   = "c1.mem"
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BX-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BY-1:0] out_data,
    output logic          busy
);
    localparam int EXP_BW    = BX - 2 - MANT_BW;
    localparam int FRAC_BW   = MANT_BW - K;
    localparam int ACC_W     = $clog2(max2(G_OCT, D_OCT) + EXP_BW) + 1;
    localparam int SEC_W     = $clog2(G_OCT + D_OCT + 2);
    localparam int ADDR_W    = SEC_W + K;
    localparam int ROM_DEPTH = (G_OCT + D_OCT + 2) * (2 ** K);
    localparam logic [ACC_W-1:0] G_MAX = ACC_W'(G_OCT);
    localparam logic [ACC_W-1:0] D_MAX = ACC_W'(D_OCT);

    logic [BY-1:0] c0_rom [ROM_DEPTH];
    logic [BY-1:0] c1_rom [ROM_DEPTH];

    function automatic logic [ACC_W-1:0] clz_field(input logic [EXP_BW-1:0] field);
        logic [ACC_W-1:0] count;
        logic             found;
        count = {ACC_W{1'b0}};
        found = 1'b0;
        for (int i = EXP_BW - 1; i >= 0; i--) begin
            if (!found && !field[i]) begin
                count = count + {{(ACC_W-1){1'b0}}, 1'b1};
            end else begin
                found = 1'b1;
            end
        end
        return count;
    endfunction

    state_t               state_r;
    state_t               state_nx_s;
    logic                 part_r;
    logic [MANT_BW-1:0]   mant_r;
    logic [ACC_W-1:0]     acc_r;
    logic [ACC_W-1:0]     max_r;
    logic [ACC_W-1:0]     oct_r;
    logic [BY-1:0]        c0_r;
    logic [BY-1:0]        c1_r;
    logic [BY-1:0]        y_r;
    logic                 symm_s;
    logic                 xfer_s;
    logic                 done_s;
    logic                 push_s;
    logic                 fifo_full_s;
    logic [EXP_BW-1:0]    field_s;
    logic [ACC_W-1:0]     acc_new_s;
    logic [ACC_W-1:0]     max_new_s;
    logic [ACC_W-1:0]     oct_new_s;
    logic [SEC_W-1:0]     section_s;
    logic [ADDR_W-1:0]    addr_s;
    logic [BY+FRAC_BW-1:0] prod_s;
    logic [BY-1:0]        y_s;
    logic [BY-1:0]        sample_s;

    assign in_ready = (state_r == S_FIRST) || (state_r == S_EXT);
    assign busy     = (state_r != S_FIRST);
    assign xfer_s   = in_valid && in_ready;
    assign push_s   = (state_r == S_PUSH) && !fifo_full_s;

    // Octave accumulation: the first word restarts the count, extension words add to it.
    always_comb begin
        field_s = in_data[BX-3:MANT_BW];
        if (state_r == S_FIRST) begin
            acc_new_s = clz_field(field_s);
            max_new_s = in_data[BX-2] ? D_MAX : G_MAX;
        end else begin
            acc_new_s = acc_r + clz_field(field_s);
            max_new_s = max_r;
        end
        done_s = (field_s != {EXP_BW{1'b0}}) || (acc_new_s >= max_new_s);
        if (acc_new_s >= max_new_s) begin
            oct_new_s = max_new_s;
        end else begin
            oct_new_s = acc_new_s;
        end
    end

    // ROM address: part=1 sections sit after the G_OCT+1 part=0 sections.
    always_comb begin
        if (part_r) begin
            section_s = SEC_W'(G_OCT + 1) + SEC_W'(oct_r);
        end else begin
            section_s = SEC_W'(oct_r);
        end
        addr_s = {section_s, mant_r[MANT_BW-1 -: K]};
    end

    // Linear segment evaluation with a full-width product before the shift.
    always_comb begin
        prod_s = {{FRAC_BW{1'b0}}, c1_r} * {{BY{1'b0}}, mant_r[FRAC_BW-1:0]};
        y_s    = c0_r + prod_s[BY+FRAC_BW-1:FRAC_BW];
        if (symm_s) begin
            sample_s = ~y_s + {{(BY-1){1'b0}}, 1'b1};
        end else begin
            sample_s = y_s;
        end
    end

`ifdef RNG_SYMM_EN
    logic symm_r;

    // Sign of the sample comes from the first word of each sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            symm_r <= 1'b0;
        end else if (xfer_s && (state_r == S_FIRST)) begin
            symm_r <= in_data[BX-1];
        end
    end

    assign symm_s = symm_r;
`else
    logic unused_symm_s;

    assign unused_symm_s = in_data[BX-1];
    assign symm_s        = 1'b0;
`endif

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_FIRST, S_EXT: begin
                if (xfer_s && done_s) begin
                    state_nx_s = S_LOOK;
                end else if (xfer_s) begin
                    state_nx_s = S_EXT;
                end else begin
                    state_nx_s = state_r;
                end
            end
            S_LOOK:  state_nx_s = S_MAC;
            S_MAC:   state_nx_s = S_PUSH;
            S_PUSH: begin
                if (!fifo_full_s) begin
                    state_nx_s = S_FIRST;
                end else begin
                    state_nx_s = S_PUSH;
                end
            end
            default: state_nx_s = S_FIRST;
        endcase
    end

    // State, sample context, ROM read and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_FIRST;
            part_r  <= 1'b0;
            mant_r  <= '0;
            acc_r   <= '0;
            max_r   <= '0;
            oct_r   <= '0;
            c0_r    <= '0;
            c1_r    <= '0;
            y_r     <= '0;
        end else begin
            state_r <= state_nx_s;
            if (xfer_s) begin
                acc_r <= acc_new_s;
                oct_r <= oct_new_s;
                if (state_r == S_FIRST) begin
                    part_r <= in_data[BX-2];
                    mant_r <= in_data[MANT_BW-1:0];
                    max_r  <= max_new_s;
                end
            end
            if (state_r == S_LOOK) begin
                c0_r <= c0_rom[addr_s];
                c1_r <= c1_rom[addr_s];
            end
            if (state_r == S_MAC) begin
                y_r <= sample_s;
            end
        end
    end

    rng_out_fifo #(
        .W     (BY),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (y_r),
        .full      (fifo_full_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_rng_icdf_sampler.sv
// Randomised and directed bench for rng_icdf_sampler against a word-stream reference model.
module tb_rng_icdf_sampler;
    localparam int G_OCT     = 10;
    localparam int D_OCT     = 6;
    localparam int ROM_DEPTH = (G_OCT + D_OCT + 2) * 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;
    int ready_mode = 1;
    int rom_c0 [ROM_DEPTH];
    int rom_c1 [ROM_DEPTH];
    int exp_q [$];

    bit m_active = 1'b0;
    int m_acc, m_max, m_part, m_symm, m_mant;

    rng_icdf_sampler #(
        .C0_FILE (""),
        .C1_FILE ("")
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic rom_write(input int idx, input int c0, input int c1);
        rom_c0[idx] = c0;
        rom_c1[idx] = c1;
        dut.c0_rom[idx] = 16'(c0);
        dut.c1_rom[idx] = 16'(c1);
    endtask

    function automatic int clz6(input int field);
        for (int i = 5; i >= 0; i--) begin
            if (field[i]) return 5 - i;
        end
        return 6;
    endfunction

    function automatic int model_sample(input int symm, input int part, input int oct, input int mant);
        int addr, frac, y;
        addr = (part != 0 ? G_OCT + 1 + oct : oct) * 8 + (mant >> 5);
        frac = mant & 31;
        y = (rom_c0[addr] + ((rom_c1[addr] * frac) >> 5)) & 32'hFFFF;
`ifdef RNG_SYMM_EN
        if (symm != 0) y = (-y) & 32'hFFFF;
`endif
        return y;
    endfunction

    // Reference: a sample ends at a word with a nonzero exponent field or when the octave reaches its clamp.
    task automatic model_accept(input logic [15:0] w);
        int field;
        field = int'(w[13:8]);
        if (!m_active) begin
            m_symm = int'(w[15]);
            m_part = int'(w[14]);
            m_mant = int'(w[7:0]);
            m_acc  = 0;
            m_max  = (m_part != 0) ? D_OCT : G_OCT;
        end
        m_acc = m_acc + clz6(field);
        if (field != 0 || m_acc >= m_max) begin
            exp_q.push_back(model_sample(m_symm, m_part, (m_acc < m_max) ? m_acc : m_max, m_mant));
            m_active = 1'b0;
        end else begin
            m_active = 1'b1;
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        int  budget;
        bit  done;
        budget   = 0;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        while (!done) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                model_accept(w);
                @(posedge clk);
                #1;
                done = 1'b1;
            end else if (budget > 300) begin
                n_vec++;
                n_bad++;
                $display("FAIL accept_timeout: word %h not taken, limit 300 cycles", w);
                done = 1'b1;
            end else begin
                budget++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [15:0] lit);
        int cyc;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check(name, out_data, lit);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || out_valid !== 1'b0 || busy !== 1'b0) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_left"}, exp_q.size(), 0);
        check({name, "_busy"}, busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // Consumer handshake pattern.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Every visible head sample must match the model's oldest outstanding sample.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_out: got %h, expected no sample", out_data);
            end else begin
                check("out_data", out_data, 32'(exp_q[0]));
                if (out_ready === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [15:0] w;
        int          lat;

        for (int i = 0; i < ROM_DEPTH; i++) rom_write(i, i, 0);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);

        // Single word, latency from accept edge to visible output.
        send_word(16'h2480);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 4);
        check("single_2480", out_data, 16'h0004);
        @(posedge clk);
        #1;

        send_word(16'h0180);
        expect_out("single_0180", 16'h002C);

        send_word(16'h00A0);
        check("ext_busy", busy, 1'b1);
        check("ext_in_ready", in_ready, 1'b1);
        send_word(16'h0400);
        expect_out("ext_00a0_0400", 16'h004D);

        send_word(16'h4000);
        expect_out("clamp_part1", 16'h0088);
        send_word(16'h0000);
        send_word(16'h2480);
        drain("clamp");

        // Backpressure: four buffered, one held, sixth word refused.
        ready_mode = 0;
        for (int i = 0; i < 5; i++) begin
            w = 16'($urandom);
            w[13:8] = 6'($urandom_range(1, 63));
            send_word(w);
        end
        repeat (6) @(posedge clk);
        #1;
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_busy", busy, 1'b1);
        check("bp_out_valid", out_valid, 1'b1);
        check("bp_pending", exp_q.size(), 5);
        w = 16'h3F11;
        in_valid = 1'b1;
        in_data  = w;
        repeat (3) begin
            @(negedge clk);
            check("bp_refuse", in_ready, 1'b0);
        end
        ready_mode = 1;
        send_word(w);
        drain("bp");

        // Reset while a sample is extending and the FIFO holds one entry.
        ready_mode = 0;
        send_word(16'h2480);
        send_word(16'h00A0);
        check("pre_rst_valid", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        exp_q.delete();
        m_active = 1'b0;
        ready_mode = 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_word(16'h2480);
        expect_out("after_rst", 16'h0004);
        drain("rst");

        // Linear term and optional negation.
        rom_write(4, 16'h0100, 16'h0040);
        send_word(16'h249F);
        expect_out("mac_249f", 16'h013E);
        send_word(16'hA49F);
`ifdef RNG_SYMM_EN
        expect_out("mac_symm", 16'hFEC2);
`else
        expect_out("mac_symm", 16'h013E);
`endif
        drain("mac");

        // Random ROM, words and consumer stalls.
        for (int i = 0; i < ROM_DEPTH; i++) rom_write(i, $urandom_range(0, 65535), $urandom_range(0, 65535));
        ready_mode = 2;
        for (int n = 0; n < 400; n++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 3) == 0) w[13:8] = 6'h00;
            send_word(w);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        send_word(16'h3F00);
        drain("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
